sum_ram_ctrl: RTL and testbench

- Sequencer for the ping-pong accumulation RAM (`sum_ram`) in the `pipeline_acc` path.
- Accumulates `I_npass` passes of `I_len` partial sums into the write bank, swaps banks, then drains the finished bank to the next stage.
- Generates every `sum_ram` control input: `dven`, `dv_pre4`, `first_flag`, `wram0_en` and the drain `raddr`.
- Accumulate and drain share the RAM read address, so the two phases never overlap.

---
 rtl/acc_pkg.sv | 19 +
 rtl/dly.sv | 25 ++
 rtl/sum_ram_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sum_ram_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for sequencing the pipeline_acc ping-pong sum RAM.
package acc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_FLUSH,
    S_CLR,
    S_SWAP,
    S_DRAIN,
    S_DTAIL
  } acc_state_t;

  // Flush must outlast the sum_ram write path so the final beat lands.
  localparam int C_SUM_RAM_WR_LAT = 7;
  localparam int C_FLUSH_DEF      = C_SUM_RAM_WR_LAT + 1;
  localparam int C_RD_LAT_DEF     = 3;

endpackage

// File: rtl/dly.sv
// Reset-able delay line: O_dout is I_din delayed by C_DLY_NUM clocks.
module dly #(
  parameter int C_DATA_WIDTH = 1,
  parameter int C_DLY_NUM    = 1
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic [C_DATA_WIDTH-1:0] I_din,
  output logic [C_DATA_WIDTH-1:0] O_dout
);

  logic [C_DATA_WIDTH-1:0] r_pipe [C_DLY_NUM];

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int i = 0; i < C_DLY_NUM; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= I_din;
      for (int i = 1; i < C_DLY_NUM; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign O_dout = r_pipe[C_DLY_NUM-1];

endmodule

// File: rtl/sum_ram_ctrl.sv
// Sequencer for the ping-pong accumulation RAM: accumulate I_npass passes,
// swap banks, then drain the finished bank. All outputs are registered.
module sum_ram_ctrl
  import acc_pkg::*;
#(
  parameter int C_ASIZE  = 10,
  parameter int C_PSIZE  = 8,
  parameter int C_FLUSH  = C_FLUSH_DEF,
  parameter int C_RD_LAT = C_RD_LAT_DEF
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_start,
  input  logic [C_ASIZE:0]   I_len,
  input  logic [C_PSIZE-1:0] I_npass,
  input  logic               I_src_vld,
  output logic               O_busy,
  output logic               O_done,
  output logic               O_dven,
  output logic               O_dv_pre4,
  output logic               O_first_flag,
  output logic               O_wram0_en,
  output logic [C_ASIZE-1:0] O_raddr,
  output logic               O_rd_vld,
  output logic [C_PSIZE-1:0] O_pass_idx
);

  localparam int C_FW = (C_FLUSH > 1) ? $clog2(C_FLUSH) : 1;
  localparam int C_TW = (C_RD_LAT > 1) ? $clog2(C_RD_LAT) : 1;

  acc_state_t         r_state, w_state_nxt;
  logic [C_ASIZE:0]   r_len, w_len_nxt;
  logic [C_PSIZE-1:0] r_npass, w_npass_nxt;
  logic [C_PSIZE-1:0] r_pass, w_pass_nxt;
  logic [C_ASIZE:0]   r_beat_cnt, w_beat_nxt;
  logic [C_FW-1:0]    r_flush_cnt, w_flush_nxt;
  logic [C_TW-1:0]    r_tail_cnt, w_tail_nxt;
  logic [C_ASIZE-1:0] r_raddr, w_raddr_nxt;
  logic               r_dven, w_dven_nxt;
  logic               r_dv_pre4, w_dv_pre4_nxt;
  logic               r_first_flag, w_first_nxt;
  logic               r_wram0_en, w_wram0_en_nxt;
  logic               r_rd_iss, w_rd_iss_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               w_start_ok;
  logic               w_last_raddr;
  logic               w_last_pass;
  logic               w_rd_vld;

  assign w_start_ok   = I_start && (r_state == S_IDLE) && !r_busy &&
                        (I_len != '0) && (I_npass != '0);
  assign w_last_raddr = ({1'b0, r_raddr} == (r_len - 1'b1));
  assign w_last_pass  = (r_pass == (r_npass - 1'b1));

  // r_beat_cnt counts beats issued up to and including the one on O_dv_pre4 now.
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_npass_nxt    = r_npass;
    w_pass_nxt     = r_pass;
    w_beat_nxt     = r_beat_cnt;
    w_flush_nxt    = r_flush_cnt;
    w_tail_nxt     = r_tail_cnt;
    w_raddr_nxt    = r_raddr;
    w_dven_nxt     = r_dven;
    w_dv_pre4_nxt  = 1'b0;
    w_first_nxt    = r_first_flag;
    w_wram0_en_nxt = r_wram0_en;
    w_rd_iss_nxt   = 1'b0;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt   = S_ACC;
          w_len_nxt     = I_len;
          w_npass_nxt   = I_npass;
          w_pass_nxt    = '0;
          w_dven_nxt    = 1'b1;
          w_first_nxt   = 1'b1;
          w_dv_pre4_nxt = I_src_vld;
          w_beat_nxt    = (C_ASIZE+1)'(I_src_vld);
        end
      end
      S_ACC: begin
        if (r_beat_cnt == r_len) begin
          w_state_nxt = S_FLUSH;
          w_flush_nxt = C_FW'(C_FLUSH - 1);
        end else begin
          w_dv_pre4_nxt = I_src_vld;
          w_beat_nxt    = r_beat_cnt + (C_ASIZE+1)'(I_src_vld);
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_nxt = S_CLR;
          w_dven_nxt  = 1'b0;
        end else begin
          w_flush_nxt = r_flush_cnt - 1'b1;
        end
      end
      S_CLR: begin
        w_first_nxt = 1'b0;
        if (w_last_pass) begin
          w_state_nxt    = S_SWAP;
          w_wram0_en_nxt = ~r_wram0_en;
        end else begin
          w_state_nxt   = S_ACC;
          w_pass_nxt    = r_pass + 1'b1;
          w_dven_nxt    = 1'b1;
          w_dv_pre4_nxt = I_src_vld;
          w_beat_nxt    = (C_ASIZE+1)'(I_src_vld);
        end
      end
      S_SWAP: begin
        w_state_nxt  = S_DRAIN;
        w_raddr_nxt  = '0;
        w_rd_iss_nxt = 1'b1;
      end
      S_DRAIN: begin
        if (w_last_raddr) begin
          w_state_nxt = S_DTAIL;
          w_raddr_nxt = '0;
          w_tail_nxt  = C_TW'(C_RD_LAT - 1);
        end else begin
          w_raddr_nxt  = r_raddr + 1'b1;
          w_rd_iss_nxt = 1'b1;
        end
      end
      S_DTAIL: begin
        if (r_tail_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_tail_nxt = r_tail_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE) || w_done_nxt;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_npass      <= '0;
      r_pass       <= '0;
      r_beat_cnt   <= '0;
      r_flush_cnt  <= '0;
      r_tail_cnt   <= '0;
      r_raddr      <= '0;
      r_dven       <= 1'b0;
      r_dv_pre4    <= 1'b0;
      r_first_flag <= 1'b0;
      r_wram0_en   <= 1'b0;
      r_rd_iss     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_npass      <= w_npass_nxt;
      r_pass       <= w_pass_nxt;
      r_beat_cnt   <= w_beat_nxt;
      r_flush_cnt  <= w_flush_nxt;
      r_tail_cnt   <= w_tail_nxt;
      r_raddr      <= w_raddr_nxt;
      r_dven       <= w_dven_nxt;
      r_dv_pre4    <= w_dv_pre4_nxt;
      r_first_flag <= w_first_nxt;
      r_wram0_en   <= w_wram0_en_nxt;
      r_rd_iss     <= w_rd_iss_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  dly #(
    .C_DATA_WIDTH (1),
    .C_DLY_NUM    (C_RD_LAT)
  ) u_rd_vld_dly (
    .I_clk  (I_clk),
    .I_rst  (I_rst),
    .I_din  (r_rd_iss),
    .O_dout (w_rd_vld)
  );

  assign O_busy       = r_busy;
  assign O_done       = r_done;
  assign O_dven       = r_dven;
  assign O_dv_pre4    = r_dv_pre4;
  assign O_first_flag = r_first_flag;
  assign O_wram0_en   = r_wram0_en;
  assign O_raddr      = r_raddr;
  assign O_rd_vld     = w_rd_vld;
  assign O_pass_idx   = r_pass;

endmodule

// File: tb/tb_sum_ram_ctrl.sv
// Self-checking bench for sum_ram_ctrl: a behavioural sum RAM driven by the
// DUT controls is compared against closed-form pass sums.
module tb_sum_ram_ctrl;

   localparam int C_ASIZE  = 10;
   localparam int C_PSIZE  = 8;
   localparam int C_FLUSH  = 8;
   localparam int C_RD_LAT = 3;
   localparam int C_DEPTH  = 1 << C_ASIZE;

   logic               I_clk = 1'b0;
   logic               I_rst;
   logic               I_start;
   logic [C_ASIZE:0]   I_len;
   logic [C_PSIZE-1:0] I_npass;
   logic               I_src_vld = 1'b0;
   logic               O_busy, O_done, O_dven, O_dv_pre4, O_first_flag;
   logic               O_wram0_en, O_rd_vld;
   logic [C_ASIZE-1:0] O_raddr;
   logic [C_PSIZE-1:0] O_pass_idx;

   sum_ram_ctrl #(
      .C_ASIZE  (C_ASIZE),
      .C_PSIZE  (C_PSIZE),
      .C_FLUSH  (C_FLUSH),
      .C_RD_LAT (C_RD_LAT)
   ) dut (
      .I_clk        (I_clk),
      .I_rst        (I_rst),
      .I_start      (I_start),
      .I_len        (I_len),
      .I_npass      (I_npass),
      .I_src_vld    (I_src_vld),
      .O_busy       (O_busy),
      .O_done       (O_done),
      .O_dven       (O_dven),
      .O_dv_pre4    (O_dv_pre4),
      .O_first_flag (O_first_flag),
      .O_wram0_en   (O_wram0_en),
      .O_raddr      (O_raddr),
      .O_rd_vld     (O_rd_vld),
      .O_pass_idx   (O_pass_idx)
   );

   // Free-running clock and cycle counter used for relative event timing.
   always #5 I_clk = ~I_clk;

   int cyc = 0;
   always @(posedge I_clk) cyc <= cyc + 1;

   int nChecks = 0;
   int nPassed = 0;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      nChecks++;
      if (actual == expected) nPassed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
   endtask

   // Job description shared with the monitor; written only by the driver.
   int jobLen = 1;
   int jobNpass = 1;
   int jobBase = 0;
   int jobStartCyc = 0;
   bit checkTiming = 1'b0;
   int srcMode = 0;
   bit expWram = 1'b0;

   // Source readiness generator: always ready, alternating, or random.
   initial begin : srcGen
      int phase;
      phase = 0;
      forever begin
         @(posedge I_clk);
         #1;
         case (srcMode)
            0: I_src_vld = 1'b1;
            1: I_src_vld = ((phase % 2) == 0);
            default: I_src_vld = ($urandom_range(3, 0) != 0);
         endcase
         phase++;
      end
   end

   // Monitor state: behavioural two-bank sum RAM plus per-job event records.
   int ram [2][C_DEPTH];
   int raddrHist [$];
   bit prevBusy, prevDven, prevWram, wramStart;
   int beats, beatsInPass, waddr, rdCount, dvenFalls;
   int firstPre4, lastPre4, lastDven, wramTogCyc, firstRd, lastRd;

   // The k-th accepted beat of a job belongs to pass k/len, word k%len, and
   // every drained word must equal the closed-form sum over all passes.
   initial begin : monitor
      int rel, p, wi, bank, word, addr, expV;
      prevBusy = 0; prevDven = 0; prevWram = 0; wramStart = 0;
      beats = 0; beatsInPass = 0; waddr = 0; rdCount = 0; dvenFalls = 0;
      firstPre4 = -1; lastPre4 = -1; lastDven = -1; wramTogCyc = -1; firstRd = -1; lastRd = -1;
      forever begin
         @(negedge I_clk);
         if (I_rst) continue;
         rel = cyc - jobStartCyc;
         if (O_busy && !prevBusy) begin
            beats = 0; beatsInPass = 0; rdCount = 0; dvenFalls = 0;
            firstPre4 = -1; lastPre4 = -1; lastDven = -1; wramTogCyc = -1; firstRd = -1; lastRd = -1;
            wramStart = O_wram0_en;
         end
         if (!O_dven) waddr = 0;
         if (O_dv_pre4) begin
            p = beats / jobLen;
            wi = beats % jobLen;
            checkOutput("firstFlag", O_first_flag, (p == 0));
            checkOutput("passIdx", O_pass_idx, p);
            bank = O_wram0_en ? 0 : 1;
            word = jobBase + 10 * p + wi;
            if (waddr < C_DEPTH) begin
               if (O_first_flag) ram[bank][waddr] = word;
               else ram[bank][waddr] = ram[bank][waddr] + word;
            end
            waddr++;
            beats++;
            beatsInPass++;
            if (firstPre4 < 0) firstPre4 = rel;
            lastPre4 = rel;
         end
         if (O_dven) lastDven = rel;
         if (prevDven && !O_dven && O_busy) begin
            dvenFalls++;
            checkOutput("beatsPerPass", beatsInPass, jobLen);
            beatsInPass = 0;
         end
         if (O_wram0_en != prevWram) wramTogCyc = rel;
         raddrHist.push_back(int'(O_raddr));
         if (raddrHist.size() > C_RD_LAT + 1) void'(raddrHist.pop_front());
         if (O_rd_vld) begin
            addr = raddrHist[0];
            checkOutput("rdAddr", addr, rdCount);
            bank = O_wram0_en ? 1 : 0;
            expV = jobNpass * (jobBase + rdCount) + 5 * jobNpass * (jobNpass - 1);
            checkOutput("rdData", ram[bank][addr % C_DEPTH], expV);
            if (firstRd < 0) firstRd = rel;
            lastRd = rel;
            rdCount++;
         end
         if (O_done) begin
            checkOutput("doneBusy", O_busy, 1);
            checkOutput("rdCount", rdCount, jobLen);
            checkOutput("beatTotal", beats, jobLen * jobNpass);
            checkOutput("passCount", dvenFalls, jobNpass);
            checkOutput("bankToggle", O_wram0_en, !wramStart);
            if (checkTiming) begin
               checkOutput("tFirstPre4", firstPre4, 1);
               checkOutput("tLastPre4", lastPre4, 4);
               checkOutput("tLastDven", lastDven, 12);
               checkOutput("tWramToggle", wramTogCyc, 14);
               checkOutput("tFirstRdVld", firstRd, 18);
               checkOutput("tLastRdVld", lastRd, 21);
               checkOutput("tDone", rel, 22);
            end
         end
         prevBusy = O_busy;
         prevDven = O_dven;
         prevWram = O_wram0_en;
      end
   end

   task automatic waitDone(input int budget);
      bit seen;
      seen = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge I_clk);
         if (O_done) seen = 1;
      end
      checkOutput("doneSeen", seen, 1);
   endtask

   // Run one job; optionally poke a bogus start while the job is busy.
   task automatic applyStimulus(input int len, input int npass, input int mode,
                                input bit timing, input bit pokeBusy);
      srcMode = mode;
      jobLen = len;
      jobNpass = npass;
      jobBase = (len == 3 && npass == 3) ? 0 : int'($urandom_range(1000, 0));
      checkTiming = timing;
      @(posedge I_clk);
      @(posedge I_clk);
      #2;
      I_len = (C_ASIZE+1)'(len);
      I_npass = C_PSIZE'(npass);
      I_start = 1'b1;
      jobStartCyc = cyc;
      @(posedge I_clk);
      #2;
      I_start = 1'b0;
      if (pokeBusy) begin
         repeat (3) @(posedge I_clk);
         #2;
         I_len = (C_ASIZE+1)'(3);
         I_npass = C_PSIZE'(1);
         I_start = 1'b1;
         @(posedge I_clk);
         #2;
         I_start = 1'b0;
      end
      waitDone(5000);
      expWram = !expWram;
      @(negedge I_clk);
      checkOutput("busyAfterDone", O_busy, 0);
      checkOutput("wramAfterJob", O_wram0_en, expWram);
      checkTiming = 1'b0;
   endtask

   task automatic applyBadStart(input int len, input int npass, input string tag);
      int seen;
      seen = 0;
      @(posedge I_clk);
      #2;
      I_len = (C_ASIZE+1)'(len);
      I_npass = C_PSIZE'(npass);
      I_start = 1'b1;
      @(posedge I_clk);
      #2;
      I_start = 1'b0;
      repeat (6) begin
         @(negedge I_clk);
         if (O_busy || O_done) seen++;
      end
      checkOutput(tag, seen, 0);
   endtask

   initial begin : driver
      int seenDone;
      bit gotDrain;
      I_rst = 1'b1;
      I_start = 1'b0;
      I_len = '0;
      I_npass = '0;
      repeat (3) @(posedge I_clk);
      @(negedge I_clk);
      checkOutput("resetOutputs", {O_busy, O_done, O_dven, O_dv_pre4, O_first_flag,
                                   O_wram0_en, O_raddr, O_rd_vld, O_pass_idx}, 0);
      @(posedge I_clk);
      #1;
      I_rst = 1'b0;

      applyStimulus(4, 1, 0, 1, 0);
      applyStimulus(3, 3, 0, 0, 0);
      applyStimulus(8, 2, 1, 0, 1);
      applyStimulus(2, 1, 0, 0, 0);
      applyStimulus(2, 1, 0, 0, 0);
      applyStimulus(1, 2, 2, 0, 0);
      applyStimulus(1024, 1, 0, 0, 0);
      applyBadStart(0, 2, "lenZeroIgnored");
      applyBadStart(5, 0, "npassZeroIgnored");
      for (int j = 0; j < 10; j++)
         applyStimulus(int'($urandom_range(20, 1)), int'($urandom_range(4, 1)), 2, 0, 0);

      // Abort a job in the middle of its drain.
      srcMode = 0;
      jobLen = 8;
      jobNpass = 1;
      jobBase = 7;
      @(posedge I_clk);
      #2;
      I_len = (C_ASIZE+1)'(8);
      I_npass = C_PSIZE'(1);
      I_start = 1'b1;
      jobStartCyc = cyc;
      @(posedge I_clk);
      #2;
      I_start = 1'b0;
      gotDrain = 0;
      for (int k = 0; k < 200 && !gotDrain; k++) begin
         @(negedge I_clk);
         if (O_rd_vld) gotDrain = 1;
      end
      checkOutput("drainReached", gotDrain, 1);
      @(posedge I_clk);
      #1;
      I_rst = 1'b1;
      @(posedge I_clk);
      #1;
      I_rst = 1'b0;
      @(negedge I_clk);
      checkOutput("abortOutputs", {O_busy, O_done, O_dven, O_dv_pre4, O_first_flag,
                                   O_wram0_en, O_raddr, O_rd_vld, O_pass_idx}, 0);
      expWram = 1'b0;
      seenDone = 0;
      repeat (12) begin
         @(negedge I_clk);
         if (O_done) seenDone++;
      end
      checkOutput("noDoneAfterAbort", seenDone, 0);

      applyStimulus(5, 2, 2, 0, 0);
      applyStimulus(6, 1, 1, 0, 0);

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
